// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a frame-synchronous load handshake.
// Define SEVENSEG_LZ_BLANK_EN to build in leading-zero blanking of digits 3..1.
module sevenseg_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  dots_in,
    input  logic        load,
    output logic        ready,
    input  logic        disp_en,
    output logic [3:0]  data,
    output logic [3:0]  en_seg,
    output logic        dt,
    output logic        frame_done
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

    typedef enum logic {
        PEND_EMPTY,
        PEND_FULL
    } pend_state_e;

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [1:0]           idx_q, idx_d;
    logic                 tick;
    logic                 frame_tick;

    pend_state_e          pend_state_q, pend_state_d;
    logic [15:0]          pend_val_q;
    logic [3:0]           pend_dots_q;
    logic                 accept;
    logic                 commit;

    logic [15:0]          disp_val_q, disp_val_d;
    logic [3:0]           disp_dots_q, disp_dots_d;

    logic                 blank;
    logic [3:0]           data_q, data_d;
    logic [3:0]           en_seg_q, en_seg_d;
    logic                 dt_q, dt_d;

    // Prescaler and digit index; the index 3->0 wrap marks the frame boundary.
    assign tick       = (div_q == DIV_LAST);
    assign frame_tick = tick && (idx_q == 2'd3);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        div_d = div_q + DIV_WIDTH'(1);
        idx_d = idx_q;
        if (tick) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Pending-slot handshake: one entry, drained only at a frame boundary.
    assign ready  = (pend_state_q == PEND_EMPTY);
    assign accept = load && ready;
    assign commit = frame_tick && (pend_state_q == PEND_FULL);

    always_comb begin
        pend_state_d = pend_state_q;
        case (pend_state_q)
            PEND_EMPTY: if (load)       pend_state_d = PEND_FULL;
            PEND_FULL:  if (frame_tick) pend_state_d = PEND_EMPTY;
            default:                    pend_state_d = PEND_EMPTY;
        endcase
    end

    always_comb begin
        disp_val_d  = disp_val_q;
        disp_dots_d = disp_dots_q;
        if (commit) begin
            disp_val_d  = pend_val_q;
            disp_dots_d = pend_dots_q;
        end
    end

`ifdef SEVENSEG_LZ_BLANK_EN
    // A digit goes dark when it and every digit to its left are zero and its dot is off.
    always_comb begin
        blank = 1'b0;
        case (idx_q)
            2'd3:    blank = (disp_val_q[15:12] == 4'h0)  && !disp_dots_q[3];
            2'd2:    blank = (disp_val_q[15:8]  == 8'h00) && !disp_dots_q[2];
            2'd1:    blank = (disp_val_q[15:4]  == 12'h0) && !disp_dots_q[1];
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        data_d   = disp_val_q[{idx_q, 2'b00} +: 4];
        en_seg_d = 4'b1111;
        dt_d     = 1'b1;
        if (disp_en && !blank) begin
            en_seg_d[idx_q] = 1'b0;
            dt_d            = ~disp_dots_q[idx_q];
        end
    end

    // NOTE: pending payload has no reset; it is only ever read while pend_state_q says FULL.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_val_q  <= value_in;
            pend_dots_q <= dots_in;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            div_q        <= '0;
            idx_q        <= 2'd0;
            pend_state_q <= PEND_EMPTY;
            disp_val_q   <= 16'h0000;
            disp_dots_q  <= 4'b0000;
            data_q       <= 4'h0;
            en_seg_q     <= 4'b1111;
            dt_q         <= 1'b1;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            pend_state_q <= pend_state_d;
            disp_val_q   <= disp_val_d;
            disp_dots_q  <= disp_dots_d;
            data_q       <= data_d;
            en_seg_q     <= en_seg_d;
            dt_q         <= dt_d;
        end
    end

    assign data       = data_q;
    assign en_seg     = en_seg_q;
    assign dt         = dt_q;
    assign frame_done = frame_tick;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl at REFRESH_DIV=4 (16-cycle frame).
// Expectations follow SEVENSEG_LZ_BLANK_EN when it is defined for the build.
module tb_sevenseg_scan_ctrl;

`ifdef SEVENSEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  dots_in;
    logic        load;
    logic        ready;
    logic        disp_en;
    logic [3:0]  data;
    logic [3:0]  en_seg;
    logic        dt;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;

    sevenseg_scan_ctrl #(
        .REFRESH_DIV(4),
        .DIV_WIDTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .dots_in   (dots_in),
        .load      (load),
        .ready     (ready),
        .disp_en   (disp_en),
        .data      (data),
        .en_seg    (en_seg),
        .dt        (dt),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic        rst;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  dots;
        logic        en;
        logic [3:0]  e_data;
        logic [3:0]  e_en;
        logic        e_dt;
        logic        e_fd;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int t, logic r, logic ld, logic [15:0] val, logic [3:0] dots,
                                logic en, logic [3:0] e_data, logic [3:0] e_en, logic e_dt,
                                logic e_fd, logic e_rdy);
        vec_t v;
        v.t = t; v.rst = r; v.ld = ld; v.val = val; v.dots = dots; v.en = en;
        v.e_data = e_data; v.e_en = e_en; v.e_dt = e_dt; v.e_fd = e_fd; v.e_rdy = e_rdy;
        return v;
    endfunction

    // Expected anode pattern for a digit that leading-zero blanking would darken.
    function automatic logic [3:0] lz(logic [3:0] lit);
        return LZ ? 4'b1111 : lit;
    endfunction

    // At most one anode may be low on any cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            check($sformatf("t%0d en_seg one-hot-low", cyc),
                  16'($countones(~en_seg) <= 1), 16'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int fd_count;
        int rdy_low;
        bit seen;

        rst = 1'b1; load = 1'b0; value_in = 16'h0; dots_in = 4'h0; disp_en = 1'b1;

        //            t    rst ld  val      dots     en  data  en_seg        dt fd rdy
        // idle scan after reset, display all zero
        vecs.push_back(mk(0,   0, 0, 16'h0,    4'b0000, 1, 4'h0, 4'b1111,     1, 0, 1));
        vecs.push_back(mk(1,   0, 0, 16'h0,    4'b0000, 1, 4'h0, 4'b1110,     1, 0, 1));
        vecs.push_back(mk(4,   0, 0, 16'h0,    4'b0000, 1, 4'h0, 4'b1110,     1, 0, 1));
        vecs.push_back(mk(5,   0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b1101), 1, 0, 1));
        vecs.push_back(mk(9,   0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b1011), 1, 0, 1));
        vecs.push_back(mk(13,  0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b0111), 1, 0, 1));
        vecs.push_back(mk(15,  0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b0111), 1, 1, 1));
        vecs.push_back(mk(16,  0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b0111), 1, 0, 1));
        vecs.push_back(mk(17,  0, 0, 16'h0,    4'b0000, 1, 4'h0, 4'b1110,     1, 0, 1));
        // mid-frame load of 1A2F, then an ignored load of FFFF while pending is full
        vecs.push_back(mk(18,  0, 1, 16'h1A2F, 4'b0100, 1, 4'h0, 4'b1110,     1, 0, 1));
        vecs.push_back(mk(19,  0, 0, 16'h0,    4'b0000, 1, 4'h0, 4'b1110,     1, 0, 0));
        vecs.push_back(mk(20,  0, 1, 16'hFFFF, 4'b1111, 1, 4'h0, 4'b1110,     1, 0, 0));
        vecs.push_back(mk(21,  0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b1101), 1, 0, 0));
        vecs.push_back(mk(31,  0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b0111), 1, 1, 0));
        vecs.push_back(mk(32,  0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b0111), 1, 0, 1));
        vecs.push_back(mk(33,  0, 0, 16'h0,    4'b0000, 1, 4'hF, 4'b1110,     1, 0, 1));
        vecs.push_back(mk(37,  0, 0, 16'h0,    4'b0000, 1, 4'h2, 4'b1101,     1, 0, 1));
        vecs.push_back(mk(41,  0, 0, 16'h0,    4'b0000, 1, 4'hA, 4'b1011,     0, 0, 1));
        vecs.push_back(mk(45,  0, 0, 16'h0,    4'b0000, 1, 4'h1, 4'b0111,     1, 0, 1));
        // load 0042 on the frame-boundary cycle: waits a whole frame before showing
        vecs.push_back(mk(47,  0, 1, 16'h0042, 4'b0000, 1, 4'h1, 4'b0111,     1, 1, 1));
        vecs.push_back(mk(48,  0, 0, 16'h0,    4'b0000, 1, 4'h1, 4'b0111,     1, 0, 0));
        vecs.push_back(mk(49,  0, 0, 16'h0,    4'b0000, 1, 4'hF, 4'b1110,     1, 0, 0));
        vecs.push_back(mk(53,  0, 0, 16'h0,    4'b0000, 1, 4'h2, 4'b1101,     1, 0, 0));
        vecs.push_back(mk(57,  0, 0, 16'h0,    4'b0000, 1, 4'hA, 4'b1011,     0, 0, 0));
        vecs.push_back(mk(61,  0, 0, 16'h0,    4'b0000, 1, 4'h1, 4'b0111,     1, 0, 0));
        vecs.push_back(mk(63,  0, 0, 16'h0,    4'b0000, 1, 4'h1, 4'b0111,     1, 1, 0));
        vecs.push_back(mk(64,  0, 0, 16'h0,    4'b0000, 1, 4'h1, 4'b0111,     1, 0, 1));
        vecs.push_back(mk(65,  0, 0, 16'h0,    4'b0000, 1, 4'h2, 4'b1110,     1, 0, 1));
        vecs.push_back(mk(69,  0, 0, 16'h0,    4'b0000, 1, 4'h4, 4'b1101,     1, 0, 1));
        vecs.push_back(mk(73,  0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b1011), 1, 0, 1));
        vecs.push_back(mk(77,  0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b0111), 1, 0, 1));
        vecs.push_back(mk(79,  0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b0111), 1, 1, 1));
        // display disabled for one frame: dark, but scanning and frame pulses continue
        vecs.push_back(mk(80,  0, 0, 16'h0,    4'b0000, 0, 4'h0, lz(4'b0111), 1, 0, 1));
        vecs.push_back(mk(81,  0, 0, 16'h0,    4'b0000, 0, 4'h2, 4'b1111,     1, 0, 1));
        vecs.push_back(mk(85,  0, 0, 16'h0,    4'b0000, 0, 4'h4, 4'b1111,     1, 0, 1));
        vecs.push_back(mk(89,  0, 0, 16'h0,    4'b0000, 0, 4'h0, 4'b1111,     1, 0, 1));
        vecs.push_back(mk(95,  0, 0, 16'h0,    4'b0000, 0, 4'h0, 4'b1111,     1, 1, 1));
        vecs.push_back(mk(96,  0, 0, 16'h0,    4'b0000, 1, 4'h0, 4'b1111,     1, 0, 1));
        vecs.push_back(mk(97,  0, 0, 16'h0,    4'b0000, 1, 4'h2, 4'b1110,     1, 0, 1));
        vecs.push_back(mk(101, 0, 0, 16'h0,    4'b0000, 1, 4'h4, 4'b1101,     1, 0, 1));
        // fill pending with BEEF, then reset together with a load: both discarded
        vecs.push_back(mk(102, 0, 1, 16'hBEEF, 4'b1111, 1, 4'h4, 4'b1101,     1, 0, 1));
        vecs.push_back(mk(103, 0, 0, 16'h0,    4'b0000, 1, 4'h4, 4'b1101,     1, 0, 0));
        vecs.push_back(mk(105, 1, 1, 16'h1234, 4'b1111, 1, 4'h0, lz(4'b1011), 1, 0, 0));
        vecs.push_back(mk(106, 0, 0, 16'h0,    4'b0000, 1, 4'h0, 4'b1111,     1, 0, 1));
        vecs.push_back(mk(107, 0, 0, 16'h0,    4'b0000, 1, 4'h0, 4'b1110,     1, 0, 1));
        vecs.push_back(mk(121, 0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b0111), 1, 1, 1));
        vecs.push_back(mk(123, 0, 0, 16'h0,    4'b0000, 1, 4'h0, 4'b1110,     1, 0, 1));
        vecs.push_back(mk(127, 0, 0, 16'h0,    4'b0000, 1, 4'h0, lz(4'b1101), 1, 0, 1));

        repeat (3) @(negedge clk);
        cyc    = 0;
        mon_on = 1'b1;

        foreach (vecs[i]) begin
            while (cyc < vecs[i].t) begin
                @(negedge clk);
                cyc++;
                load = 1'b0;
            end
            check($sformatf("t%0d data", cyc),       16'(data),       16'(vecs[i].e_data));
            check($sformatf("t%0d en_seg", cyc),     16'(en_seg),     16'(vecs[i].e_en));
            check($sformatf("t%0d dt", cyc),         16'(dt),         16'(vecs[i].e_dt));
            check($sformatf("t%0d frame_done", cyc), 16'(frame_done), 16'(vecs[i].e_fd));
            check($sformatf("t%0d ready", cyc),      16'(ready),      16'(vecs[i].e_rdy));
            rst      = vecs[i].rst;
            load     = vecs[i].ld;
            value_in = vecs[i].val;
            dots_in  = vecs[i].dots;
            disp_en  = vecs[i].en;
        end

        // Frame pulse cadence: next pulse within a frame, then exactly 4 one-cycle pulses per 64 cycles.
        @(negedge clk);
        cyc++;
        load = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 32 && !seen; k++) begin
            if (frame_done) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("frame_done within one frame", 16'(seen), 16'd1);

        fd_count = 0;
        rdy_low  = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            cyc++;
            if (frame_done) fd_count++;
            if (!ready) rdy_low++;
        end
        check("frame_done pulses per 64 cycles", 16'(fd_count), 16'd4);
        check("ready held high while idle", 16'(rdy_low), 16'd0);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (minimum 2).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, prescaler counter width (must hold REFRESH_DIV-1).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port value_in  input  16  four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-006 SHALL have port dots_in  input  4  per-digit dot request, bit n = digit n, 1 = lit.
REQ-007 SHALL have port load  input  1  request to capture value_in/dots_in.
REQ-008 SHALL have port ready  output  1  high when a load will be accepted.
REQ-009 SHALL have port disp_en  input  1  0 = all digits dark.
REQ-010 SHALL have port data  output  4  nibble to the seven-segment decoder.
REQ-011 SHALL have port en_seg  output  4  digit anode enables, active-low, one-hot-low.
REQ-012 SHALL have port dt  output  1  decimal point, active-low.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick asserted on the cycle count = REFRESH_DIV-1.
REQ-015 Digit index (2 bits) SHALL advance 0->1->2->3->0 on each tick; index 3->0 wrap is the frame boundary.
REQ-016 frame_done SHALL be high exactly on the cycle the frame-boundary tick occurs.
REQ-017 Handshake: load accepted when load=1 and ready=1; value_in/dots_in captured into a pending register that cycle.
REQ-018 ready SHALL fall the cycle after an accept and stay low while pending is full; load while ready=0 SHALL be ignored.
REQ-019 On a frame-boundary tick with pending full, pending SHALL copy into the display register and pending clears; ready rises the following cycle.
REQ-020 A load accepted on the same cycle as a frame-boundary tick SHALL be applied at the next boundary, not the current one.
REQ-021 Display register SHALL change only at frame boundaries (no tearing within a frame).
REQ-022 data, en_seg, dt SHALL be registered, reflecting digit index and display register with one-cycle latency.
REQ-023 data SHALL equal display nibble [4i+3:4i] for current index i; en_seg bit i low, others high; dt = ~dots bit i.
REQ-024 With disp_en=0, en_seg SHALL be 4'b1111 and dt 1; scanning, prescaler and handshake continue unaffected.
REQ-025 en_seg SHALL never have more than one bit low in any cycle.

Reset
REQ-026 On rst=1 at a clock edge: prescaler 0, digit index 0, display register 0, dots 0, pending empty.
REQ-027 Output reset values: data 4'h0, en_seg 4'b1111, dt 1, frame_done 0, ready 1.
REQ-028 Reset mid-frame or with pending full SHALL discard pending contents; rst SHALL override a simultaneous load.

Configuration
REQ-029 Macro SEVENSEG_LZ_BLANK_EN SHALL enable leading-zero blanking.
REQ-030 Defined: digit n (n=3,2,1) SHALL be dark (en_seg bit high, dt 1) when nibble n and all higher nibbles are 0 and dots bit n is 0; digit 0 never blanked.
REQ-031 Undefined: all four digits SHALL be driven regardless of value; no blanking logic synthesised.

Verification (REFRESH_DIV=4, frame = 16 cycles)
REQ-032 Reset release, disp_en=1, no load -> en_seg cycles 1110,1101,1011,0111 every 4 cycles, data 0, frame_done every 16 cycles.
REQ-033 load value_in=16'h1A2F, dots_in=4'b0100 mid-frame -> ready low next cycle; after next frame_done data sequence F,2,A,1; dt low only during digit 2; ready high again.
REQ-034 Second load while ready=0 with 16'hFFFF -> ignored; display stays 16'h1A2F.
REQ-035 load coincident with frame_done, value 16'h0042 -> not shown in current frame, shown after following frame_done; with SEVENSEG_LZ_BLANK_EN digits 3,2 dark, without it shown as 0.
REQ-036 disp_en=0 for one frame -> en_seg 1111, dt 1 throughout, frame_done pulses unchanged; re-enable resumes at current index.
REQ-037 rst asserted with pending full mid-frame -> all outputs at reset values next cycle, old pending never displayed.
